// File: rtl/sprite_plotter.sv
//==============================================================================
// Module   : sprite_plotter
// Brief    : Walks a sprite ROM in linear order and plots it through the
//            vga_adapter interface. Optional macro: SPRITE_PLOTTER_TRANSPARENT_EN
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module sprite_plotter #(
    parameter int SPR_W    = 6,
    parameter int SPR_H    = 6,
    parameter int ADDR_W   = 6,
    parameter int COLOUR_W = 3,
    parameter int SCR_W    = 160,
    parameter int SCR_H    = 120
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                start,
    input  logic [7:0]          x_origin,
    input  logic [6:0]          y_origin,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [COLOUR_W-1:0] rom_q,
    output logic [7:0]          x,
    output logic [6:0]          y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic                busy,
    output logic                done
);

    localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(SPR_W * SPR_H - 1);
    localparam logic [7:0]        C_COL_LAST  = 8'(SPR_W - 1);
    localparam logic [8:0]        C_SCR_W     = 9'(SCR_W);
    localparam logic [7:0]        C_SCR_H     = 8'(SCR_H);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [7:0]            x0_q, x0_d;
    logic [6:0]            y0_q, y0_d;
    logic [7:0]            col_q, col_d;
    logic [6:0]            row_q, row_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic                  drain_q, drain_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    // Stage 1 travels alongside the synchronous ROM read
    logic                  s1_valid_q, s1_valid_d;
    logic                  s1_vis_q, s1_vis_d;
    logic [7:0]            s1_x_q, s1_x_d;
    logic [6:0]            s1_y_q, s1_y_d;

    logic [7:0]            x_q, x_d;
    logic [6:0]            y_q, y_d;
    logic [COLOUR_W-1:0]   colour_q, colour_d;
    logic                  plot_q, plot_d;

    logic [8:0]            w_x_wide;
    logic [7:0]            w_y_wide;
    logic                  w_opaque;

    // Wide sums so that wrap-around past 255/127 is seen as off-screen
    assign w_x_wide = {1'b0, x0_q} + {1'b0, col_q};
    assign w_y_wide = {1'b0, y0_q} + {1'b0, row_q};

`ifdef SPRITE_PLOTTER_TRANSPARENT_EN
    assign w_opaque = (rom_q != '0);
`else
    assign w_opaque = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        x0_d       = x0_q;
        y0_d       = y0_q;
        col_d      = col_q;
        row_d      = row_q;
        addr_d     = addr_q;
        drain_d    = drain_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        s1_valid_d = 1'b0;
        s1_vis_d   = s1_vis_q;
        s1_x_d     = s1_x_q;
        s1_y_d     = s1_y_q;
        x_d        = x_q;
        y_d        = y_q;
        colour_d   = colour_q;
        plot_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x0_d    = x_origin;
                    y0_d    = y_origin;
                    col_d   = '0;
                    row_d   = '0;
                    addr_d  = '0;
                    busy_d  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                s1_valid_d = 1'b1;
                s1_vis_d   = (w_x_wide < C_SCR_W) && (w_y_wide < C_SCR_H);
                s1_x_d     = w_x_wide[7:0];
                s1_y_d     = w_y_wide[6:0];
                if (addr_q == C_LAST_ADDR) begin
                    drain_d = 1'b0;
                    state_d = S_DRAIN;
                end else begin
                    addr_d = addr_q + 1'b1;
                    if (col_q == C_COL_LAST) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_q) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    drain_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (s1_valid_q) begin
            plot_d   = s1_vis_q && w_opaque;
            x_d      = s1_x_q;
            y_d      = s1_y_q;
            colour_d = rom_q;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            x0_q       <= '0;
            y0_q       <= '0;
            col_q      <= '0;
            row_q      <= '0;
            addr_q     <= '0;
            drain_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_vis_q   <= 1'b0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            x_q        <= '0;
            y_q        <= '0;
            colour_q   <= '0;
            plot_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            x0_q       <= x0_d;
            y0_q       <= y0_d;
            col_q      <= col_d;
            row_q      <= row_d;
            addr_q     <= addr_d;
            drain_q    <= drain_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            s1_valid_q <= s1_valid_d;
            s1_vis_q   <= s1_vis_d;
            s1_x_q     <= s1_x_d;
            s1_y_q     <= s1_y_d;
            x_q        <= x_d;
            y_q        <= y_d;
            colour_q   <= colour_d;
            plot_q     <= plot_d;
        end
    end

    assign rom_addr = addr_q;
    assign x        = x_q;
    assign y        = y_q;
    assign colour   = colour_q;
    assign plot     = plot_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

`default_nettype wire

// File: tb/tb_sprite_plotter.sv
//==============================================================================
// Module   : tb_sprite_plotter
// Brief    : Self-checking bench for sprite_plotter against a per-pixel model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_sprite_plotter;

    localparam int N = 36;

    logic       clock = 1'b0;
    logic       resetn;
    logic       start;
    logic [7:0] x_origin;
    logic [6:0] y_origin;
    logic [5:0] rom_addr;
    logic [2:0] rom_q;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2:0] rom_mem [0:63];
    bit         exp_plot [0:N-1];
    int         exp_x    [0:N-1];
    int         exp_y    [0:N-1];
    int         exp_c    [0:N-1];
    int         exp_count;

    sprite_plotter dut (
        .clock    (clock),
        .resetn   (resetn),
        .start    (start),
        .x_origin (x_origin),
        .y_origin (y_origin),
        .rom_addr (rom_addr),
        .rom_q    (rom_q),
        .x        (x),
        .y        (y),
        .colour   (colour),
        .plot     (plot),
        .busy     (busy),
        .done     (done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) rom_q <= rom_mem[rom_addr];

    // Expected plot list straight from the screen-coordinate rules
    function automatic void build_model(input int xo, input int yo);
        exp_count = 0;
        for (int k = 0; k < N; k++) begin
            int xw, yw;
            bit vis;
            xw  = xo + (k % 6);
            yw  = yo + (k / 6);
            vis = (xw < 160) && (yw < 120);
`ifdef SPRITE_PLOTTER_TRANSPARENT_EN
            if (rom_mem[k] == 3'd0) vis = 1'b0;
`endif
            exp_plot[k] = vis;
            exp_x[k]    = xw;
            exp_y[k]    = yw;
            exp_c[k]    = int'(rom_mem[k]);
            if (vis) exp_count++;
        end
    endfunction

    task automatic run_draw(input int xo, input int yo, input bit hold,
                            input int ign_a, input int ign_b, input string name);
        int ndraw;
        int nplots;
        ndraw  = hold ? 2 : 1;
        nplots = 0;
        build_model(xo, yo);
        @(negedge clock);
        x_origin = 8'(xo);
        y_origin = 7'(yo);
        start    = 1'b1;
        for (int c = 0; c < 40 * ndraw; c++) begin
            int j;
            bit e_busy, e_done, e_plot;
            int e_addr;
            j = c % 40;
            @(negedge clock);
            start = hold ? (c < 40 * ndraw - 1) : (c == ign_a || c == ign_b);
            if (!hold) begin
                x_origin = 8'($urandom);
                y_origin = 7'($urandom);
            end
            e_busy = (j <= 37);
            e_done = (j == 38);
            e_addr = (j < N) ? j : N - 1;
            e_plot = (j >= 2 && j <= 37) ? exp_plot[j-2] : 1'b0;

            n_checks++;
            if (busy !== e_busy) begin
                n_fail++;
                $display("FAIL %s busy cycle %0d: got %b want %b", name, j, busy, e_busy);
            end
            n_checks++;
            if (done !== e_done) begin
                n_fail++;
                $display("FAIL %s done cycle %0d: got %b want %b", name, j, done, e_done);
            end
            n_checks++;
            if (int'(rom_addr) !== e_addr) begin
                n_fail++;
                $display("FAIL %s rom_addr cycle %0d: got %0d want %0d", name, j, rom_addr, e_addr);
            end
            n_checks++;
            if (plot !== e_plot) begin
                n_fail++;
                $display("FAIL %s plot cycle %0d: got %b want %b", name, j, plot, e_plot);
            end
            if (e_plot && plot === 1'b1) begin
                nplots++;
                n_checks++;
                if (int'(x) !== exp_x[j-2] || int'(y) !== exp_y[j-2] || int'(colour) !== exp_c[j-2]) begin
                    n_fail++;
                    $display("FAIL %s pixel cycle %0d: got (%0d,%0d) c%0d want (%0d,%0d) c%0d",
                             name, j, x, y, colour, exp_x[j-2], exp_y[j-2], exp_c[j-2]);
                end
            end
            if (j == 39) begin
                n_checks++;
                if (nplots !== exp_count) begin
                    n_fail++;
                    $display("FAIL %s plot count: got %0d want %0d", name, nplots, exp_count);
                end
                nplots = 0;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        resetn   = 1'b0;
        start    = 1'b0;
        x_origin = '0;
        y_origin = '0;
        #1;
        n_checks++;
        if ({rom_addr, x, y, colour, plot, busy, done} !== '0) begin
            n_fail++;
            $display("FAIL reset outputs: got addr=%0d x=%0d y=%0d c=%0d p=%b b=%b d=%b want all 0",
                     rom_addr, x, y, colour, plot, busy, done);
        end
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_basic();
        for (int k = 0; k < 64; k++) rom_mem[k] = 3'(k % 8);
        run_draw(10, 20, 1'b0, -1, -1, "basic");
    endtask

    task automatic test_clipping();
        run_draw(157, 118, 1'b0, -1, -1, "clip");
    endtask

    task automatic test_ignored_start();
        run_draw(40, 50, 1'b0, 5, 38, "ignored_start");
    endtask

    task automatic test_reset_mid_draw();
        @(negedge clock);
        x_origin = 8'd30;
        y_origin = 7'd40;
        start    = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (10) @(negedge clock);
        resetn = 1'b0;
        #1;
        n_checks++;
        if ({rom_addr, plot, busy, done} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got addr=%0d p=%b b=%b d=%b want all 0",
                     rom_addr, plot, busy, done);
        end
        @(negedge clock);
        resetn = 1'b1;
        run_draw(30, 40, 1'b0, -1, -1, "after_reset");
    endtask

    task automatic test_transparency();
        for (int k = 0; k < 64; k++) rom_mem[k] = (k % 2 == 0) ? 3'd0 : 3'd5;
        run_draw(0, 0, 1'b0, -1, -1, "transparency");
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 64; k++) rom_mem[k] = 3'($urandom);
        run_draw(70, 60, 1'b1, -1, -1, "back_to_back");
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            for (int k = 0; k < 64; k++) rom_mem[k] = 3'($urandom);
            run_draw(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                     1'b0, int'($urandom_range(0, 38)), -1, "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clipping();
        test_ignored_start();
        test_reset_mid_draw();
        test_transparency();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
